// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants for the common-data-bus arbiter
//
// Purpose: source encodings carried on cdb_src and the default geometry of the
// result bus. ROB_ID_W is rob_bit+1, so the default of 3 matches a 4-entry ROB
// with one wrap bit.
package cdb_arbiter_pkg;

  // Value driven on cdb_src to name the producer of the broadcast result.
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  localparam int CDB_ROB_ID_W_DEF   = 3;
  localparam int CDB_DATA_W_DEF     = 32;
  localparam int CDB_FIFO_DEPTH_DEF = 2;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-producer result FIFO feeding the CDB arbiter
//
// Purpose: small circular buffer holding {rob_id, value} results from one
// producer until the arbiter grants it the bus.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   rdy       global enable; 0 freezes pointers and count
//   flush     empties the FIFO (only acted on when rdy=1); beats push/pop
//   push, din write din at the tail (ignored when full)
//   pop       drop the head (ignored when empty)
//   dout      current head entry
//   empty     no entries held
//   full      DEPTH entries held
module cdb_src_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  // A flush cycle neither accepts nor releases anything.
  assign do_push = rdy && !flush && push && !full;
  assign do_pop  = rdy && !flush && pop && !empty;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);
  assign dout  = mem_q[rd_q];

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own; the
  // separate count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + 1'b1;
        if (do_pop)  rd_q <= rd_q + 1'b1;
        case ({do_push, do_pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // Storage carries no reset; stale slots are unreachable once the count is 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter for the single ROB result-write bus
//
// Purpose: ALU and LSB results queue in their own FIFO; each enabled cycle one
// head is granted (round-robin under contention) and registered onto cdb_*.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rdy                           global enable; 0 holds all state and outputs
//   clear                         ROB flush: drop everything queued, idle bus
//   alu_valid/rob_id/value/ready  ALU result offer and FIFO-not-full
//   lsb_valid/rob_id/value/ready  LSB result offer and FIFO-not-full
//   cdb_valid                     one-cycle broadcast pulse (qualify with rdy)
//   cdb_rob_id, cdb_value         broadcast payload, held when idle
//   cdb_src                       producer of the broadcast (0 ALU, 1 LSB)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W   = CDB_ROB_ID_W_DEF,
  parameter int DATA_W     = CDB_DATA_W_DEF,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src
);

  localparam int W = ROB_ID_W + DATA_W;

  logic [W-1:0] alu_dout, lsb_dout, grant_data;
  logic         alu_empty, alu_full, lsb_empty, lsb_full;
  logic         any_req, grant_src, do_grant;

  logic                rr_q, rr_d;
  logic                valid_q, valid_d;
  logic                src_q, src_d;
  logic [ROB_ID_W-1:0] id_q, id_d;
  logic [DATA_W-1:0]   value_q, value_d;

  // Ready looks at the registered count only: a pop in the same cycle does not
  // free a slot for the producer until the next cycle.
  assign alu_ready = rdy && !alu_full;
  assign lsb_ready = rdy && !lsb_full;

  cdb_src_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (clear),
    .push  (alu_valid && alu_ready),
    .din   ({alu_rob_id, alu_value}),
    .pop   (do_grant && (grant_src == CDB_SRC_ALU)),
    .dout  (alu_dout),
    .empty (alu_empty),
    .full  (alu_full)
  );

  cdb_src_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (clear),
    .push  (lsb_valid && lsb_ready),
    .din   ({lsb_rob_id, lsb_value}),
    .pop   (do_grant && (grant_src == CDB_SRC_LSB)),
    .dout  (lsb_dout),
    .empty (lsb_empty),
    .full  (lsb_full)
  );

  // Only contention consults rr_q; a lone requester always wins.
  assign any_req    = !alu_empty || !lsb_empty;
  assign grant_src  = lsb_empty ? CDB_SRC_ALU : (alu_empty ? CDB_SRC_LSB : rr_q);
  assign grant_data = (grant_src == CDB_SRC_LSB) ? lsb_dout : alu_dout;
  assign do_grant   = rdy && !clear && any_req;

  always_comb begin
    rr_d    = rr_q;
    valid_d = valid_q;
    src_d   = src_q;
    id_d    = id_q;
    value_d = value_q;
    if (rdy) begin
      if (clear) begin
        valid_d = 1'b0;
        rr_d    = 1'b0;
      end else if (any_req) begin
        valid_d = 1'b1;
        src_d   = grant_src;
        id_d    = grant_data[W-1:DATA_W];
        value_d = grant_data[DATA_W-1:0];
        // Point at the other source so the loser of a contended cycle wins next.
        rr_d    = ~grant_src;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= 1'b0;
      valid_q <= 1'b0;
      src_q   <= CDB_SRC_ALU;
      id_q    <= '0;
      value_q <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      id_q    <= id_d;
      value_q <= value_d;
    end
  end

  assign cdb_valid  = valid_q;
  assign cdb_src    = src_q;
  assign cdb_rob_id = id_q;
  assign cdb_value  = value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int RW = 3;
  localparam int DW = 32;
  localparam int D  = 2;

  localparam int K_RST  = 0;
  localparam int K_ACT  = 1;
  localparam int K_STL  = 2;
  localparam int K_NONE = 3;

  logic          clk = 1'b0;
  logic          rst, rdy, clear;
  logic          alu_valid, lsb_valid;
  logic [RW-1:0] alu_rob_id, lsb_rob_id;
  logic [DW-1:0] alu_value, lsb_value;
  logic          alu_ready, lsb_ready;
  logic          cdb_valid, cdb_src;
  logic [RW-1:0] cdb_rob_id;
  logic [DW-1:0] cdb_value;

  cdb_arbiter #(.ROB_ID_W(RW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          src;
    logic [RW-1:0] id;
    logic [DW-1:0] v;
  } ent_t;

  ent_t qa[$];
  ent_t ql[$];
  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mdl_kind = K_NONE;
  bit   mdl_rr   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: each producer is a queue of at most D results; every
  // enabled edge hands one queued result to the bus (alternating when both
  // wait) and then accepts offers against the occupancy seen before the edge.
  initial begin
    bit a_ok, l_ok;
    forever begin
      @(posedge clk);
      if (rst) begin
        qa.delete();
        ql.delete();
        exp_q.delete();
        mdl_rr   = 1'b0;
        mdl_kind = K_RST;
      end else if (!rdy) begin
        mdl_kind = K_STL;
      end else begin
        mdl_kind = K_ACT;
        if (clear) begin
          qa.delete();
          ql.delete();
          mdl_rr = 1'b0;
        end else begin
          a_ok = qa.size() < D;
          l_ok = ql.size() < D;
          if (qa.size() > 0 && (ql.size() == 0 || mdl_rr == 1'b0)) begin
            exp_q.push_back(qa.pop_front());
            mdl_rr = 1'b1;
          end else if (ql.size() > 0) begin
            exp_q.push_back(ql.pop_front());
            mdl_rr = 1'b0;
          end
          if (alu_valid && a_ok) qa.push_back('{1'b0, alu_rob_id, alu_value});
          if (lsb_valid && l_ok) ql.push_back('{1'b1, lsb_rob_id, lsb_value});
        end
      end
    end
  end

  // Monitor: compares what the bus shows after each edge with the scoreboard.
  initial begin
    logic [36:0] prev, cur;
    ent_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      case (mdl_kind)
        K_RST: chk("reset_out", 64'(cur), 64'd0);
        K_ACT: begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("broadcast", 64'(cur), 64'({1'b1, e}));
          end else begin
            chk("idle_valid", 64'(cdb_valid), 64'd0);
            chk("idle_hold", 64'(cur[35:0]), 64'(prev[35:0]));
          end
        end
        K_STL: chk("stall_hold", 64'(cur), 64'(prev));
        default: ;
      endcase
      if (mdl_kind != K_NONE) begin
        chk("alu_ready", 64'(alu_ready), 64'(rdy && (qa.size() < D)));
        chk("lsb_ready", 64'(lsb_ready), 64'(rdy && (ql.size() < D)));
      end
      prev = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    int acc;
    rst = 1'b1; rdy = 1'b0; clear = 1'b0;
    alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;

    // Reset then enable.
    repeat (2) tick();
    rst = 1'b0; rdy = 1'b1;
    tick();

    // Single ALU result.
    alu_valid = 1'b1; alu_rob_id = 3'd3; alu_value = 32'h11;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Contention from rr_ptr=0 (clear realigns the pointer).
    clear = 1'b1;
    tick();
    clear = 1'b0;
    alu_valid = 1'b1; alu_rob_id = 3'd1; alu_value = 32'hA;
    lsb_valid = 1'b1; lsb_rob_id = 3'd2; lsb_value = 32'hB;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Back-pressure: LSB streams while ALU pushes 4 with hold-and-retry.
    acc = 0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      alu_valid = 1'b1; alu_rob_id = 3'(acc + 4); alu_value = 32'hA0 + 32'(acc);
      lsb_valid = 1'b1; lsb_rob_id = 3'($urandom); lsb_value = $urandom;
      if (alu_ready) acc++;
      tick();
    end
    chk("bp_all_accepted", 64'(acc), 64'd4);
    idle_inputs();
    repeat (6) tick();

    // Flush with entries pending and a fresh ALU offer in the flush cycle.
    alu_valid = 1'b1; alu_rob_id = 3'd4; alu_value = 32'h44;
    lsb_valid = 1'b1; lsb_rob_id = 3'd5; lsb_value = 32'h55;
    tick();
    lsb_valid = 1'b0; alu_rob_id = 3'd6; alu_value = 32'h66;
    tick();
    alu_rob_id = 3'd7; alu_value = 32'h77; clear = 1'b1;
    tick();
    idle_inputs();
    repeat (4) tick();

    // Stall with entries pending.
    alu_valid = 1'b1; alu_rob_id = 3'd1; alu_value = 32'hC1;
    lsb_valid = 1'b1; lsb_rob_id = 3'd2; lsb_value = 32'hC2;
    tick();
    idle_inputs();
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    repeat (4) tick();

    // Randomized traffic with stalls, flushes and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      alu_valid  = ($urandom_range(0, 9) < 6);
      alu_rob_id = 3'($urandom);
      alu_value  = $urandom;
      lsb_valid  = ($urandom_range(0, 9) < 5);
      lsb_rob_id = 3'($urandom);
      lsb_value  = $urandom;
      tick();
    end
    rst = 1'b0; rdy = 1'b1; idle_inputs();
    repeat (6) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
